// File: rtl/ocp_debug_slave.sv
// OCP-style 8-bit debug slave: single WR/RD commands with programmable accept and
// read-response wait states, serving ID, scratch, control, event counter and link status.
`timescale 1ns/1ps
module ocp_debug_slave #(
   parameter int         P_ACCEPT_WAIT = 1,
   parameter int         P_RESP_WAIT   = 2,
   parameter logic [7:0] P_ID          = 8'h5A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] MCmd,
   input  logic [7:0] MAddr,
   input  logic [7:0] MData,
   output logic       SCmdAccept,
   output logic [7:0] SData,
   output logic [1:0] SResp,
   input  logic       event_in,
   input  logic [1:0] active_link,
   input  logic [1:0] link_state,
   output logic [7:0] dbg_ctrl
);

   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;
   localparam logic [1:0] RESP_DVA = 2'b01;
   localparam logic [1:0] RESP_ERR = 2'b11;
   localparam logic [3:0] ACC_LOAD = 4'(P_ACCEPT_WAIT - 1);
   localparam logic [3:0] RSP_LOAD = 4'(P_RESP_WAIT - 1);

   typedef enum logic [2:0] {IDLE, ACC_WAIT, ACCEPT, RD_WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        cmd_rd;
   logic [6:0]  addr_q;
   logic [7:0]  data_q;
   logic [7:0]  scratch;
   logic [7:0]  evt_hi;
   logic [15:0] evt_cnt;

   logic        mapped;
   logic [2:0]  idx;
   logic        evt_clr;
   logic        rd_err;
   logic [7:0]  rd_data;
   logic        unused_addr_msb;

   // Bit 7 only selects the debugger branch upstream; it plays no part in decode here.
   assign unused_addr_msb = MAddr[7];

   assign mapped  = (addr_q[6:3] == 4'd0);
   assign idx     = addr_q[2:0];
   assign evt_clr = (state == ACCEPT) && !cmd_rd && mapped && (idx == 3'd5) && data_q[0];

   always_comb begin
      rd_err  = 1'b0;
      rd_data = 8'h00;
      if (!mapped) begin
         rd_err = 1'b1;
      end else begin
         case (idx)
            3'd0:    rd_data = P_ID;
            3'd1:    rd_data = scratch;
            3'd2:    rd_data = dbg_ctrl;
            3'd3:    rd_data = evt_cnt[7:0];
            3'd4:    rd_data = evt_hi;
            3'd5:    rd_data = 8'h00;
            3'd6:    rd_data = {4'b0000, link_state, active_link};
            default: rd_err  = 1'b1;
         endcase
      end
   end

   // Command FSM; accept and response strobes default low so each lasts a single cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         cmd_rd     <= 1'b0;
         addr_q     <= 7'd0;
         data_q     <= 8'h00;
         scratch    <= 8'h00;
         dbg_ctrl   <= 8'h00;
         evt_hi     <= 8'h00;
         SCmdAccept <= 1'b0;
         SResp      <= 2'b00;
         SData      <= 8'h00;
      end else begin
         SCmdAccept <= 1'b0;
         SResp      <= 2'b00;
         SData      <= 8'h00;
         case (state)
            IDLE: begin
               if ((MCmd == CMD_WR) || (MCmd == CMD_RD)) begin
                  cmd_rd   <= (MCmd == CMD_RD);
                  addr_q   <= MAddr[6:0];
                  data_q   <= MData;
                  wait_cnt <= ACC_LOAD;
                  state    <= ACC_WAIT;
               end
            end
            ACC_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  SCmdAccept <= 1'b1;
                  state      <= ACCEPT;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ACCEPT: begin
               if (cmd_rd) begin
                  wait_cnt <= RSP_LOAD;
                  state    <= RD_WAIT;
               end else begin
                  if (mapped && (idx == 3'd1)) scratch  <= data_q;
                  if (mapped && (idx == 3'd2)) dbg_ctrl <= data_q;
                  state <= IDLE;
               end
            end
            RD_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  SResp <= rd_err ? RESP_ERR : RESP_DVA;
                  SData <= rd_err ? 8'h00 : rd_data;
                  if (mapped && (idx == 3'd3)) evt_hi <= evt_cnt[15:8];
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Saturating event counter; a clear in the same cycle as an event wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_cnt <= 16'h0000;
      end else if (evt_clr) begin
         evt_cnt <= 16'h0000;
      end else if (event_in && (evt_cnt != 16'hFFFF)) begin
         evt_cnt <= evt_cnt + 16'h0001;
      end
   end

endmodule

// File: tb/tb_ocp_debug_slave.sv
// Scoreboard bench for ocp_debug_slave: two instances (default waits, and accept=3/resp=4)
// driven with directed commands; a negedge monitor checks every read response.
`timescale 1ns/1ps
module tb_ocp_debug_slave;

   localparam logic [2:0] WR = 3'b001;
   localparam logic [2:0] RD = 3'b010;

   typedef struct {
      logic [1:0] resp;
      logic [7:0] data;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n0, rst_n1;
   logic [2:0] mcmd0, mcmd1;
   logic [7:0] maddr0, maddr1, mdata0, mdata1;
   logic       sca0, sca1;
   logic [7:0] sdata0, sdata1, ctrl0, ctrl1;
   logic [1:0] sresp0, sresp1;
   logic       evt0, evt1;
   logic [1:0] al0, ls0, al1, ls1;

   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   acc0 = 0;
   int   acc1 = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #10 clk = ~clk;

   ocp_debug_slave dut0 (
      .clk(clk), .rst_n(rst_n0), .MCmd(mcmd0), .MAddr(maddr0), .MData(mdata0),
      .SCmdAccept(sca0), .SData(sdata0), .SResp(sresp0), .event_in(evt0),
      .active_link(al0), .link_state(ls0), .dbg_ctrl(ctrl0)
   );

   ocp_debug_slave #(.P_ACCEPT_WAIT(3), .P_RESP_WAIT(4), .P_ID(8'h5A)) dut1 (
      .clk(clk), .rst_n(rst_n1), .MCmd(mcmd1), .MAddr(maddr1), .MData(mdata1),
      .SCmdAccept(sca1), .SData(sdata1), .SResp(sresp1), .event_in(evt1),
      .active_link(al1), .link_state(ls1), .dbg_ctrl(ctrl1)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sca0) acc0 <= acc0 + 1;
      if (sca1) acc1 <= acc1 + 1;
   end

   function automatic int pa(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int pr(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic logic getSca(input int k);
      return (k == 0) ? sca0 : sca1;
   endfunction

   function automatic int getAcc(input int k);
      return (k == 0) ? acc0 : acc1;
   endfunction

   function automatic int qSize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic setBus(input int k, input logic [2:0] c, input logic [7:0] a, input logic [7:0] d);
      if (k == 0) begin
         mcmd0 = c; maddr0 = a; mdata0 = d;
      end else begin
         mcmd1 = c; maddr1 = a; mdata1 = d;
      end
   endtask

   // Response monitor: pops one expectation per SResp pulse and checks value and timing.
   task automatic monCheck(input int k, input logic [1:0] resp, input logic [7:0] data);
      exp_t e;
      if (resp != 2'b00) begin
         if (qSize(k) == 0) begin
            checkOutput($sformatf("unexpected_resp_dut%0d", k), int'(resp), 0);
         end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            checkOutput($sformatf("sresp_dut%0d", k), int'(resp), int'(e.resp));
            checkOutput($sformatf("sdata_dut%0d", k), int'(data), int'(e.data));
            checkOutput($sformatf("resp_cycle_dut%0d", k), cyc, e.due);
         end
      end else if (data != 8'h00) begin
         checkOutput($sformatf("sdata_idle_dut%0d", k), int'(data), 0);
      end
   endtask

   always @(negedge clk) begin
      monCheck(0, sresp0, sdata0);
      monCheck(1, sresp1, sdata1);
   end

   // Issue one command, hold it until accepted, check accept latency and accept count.
   task automatic applyStimulus(input int k, input logic [2:0] c, input logic [7:0] a,
                                input logic [7:0] d, input logic [1:0] er, input logic [7:0] ed);
      int   c0;
      int   a0;
      logic got;
      exp_t e;
      @(negedge clk);
      c0 = cyc;
      a0 = getAcc(k);
      if (c == RD) begin
         e.resp = er;
         e.data = ed;
         e.due  = c0 + pa(k) + 1 + pr(k) + 1;
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      setBus(k, c, a, d);
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (getSca(k)) got = 1'b1;
      end
      setBus(k, 3'b000, 8'h00, 8'h00);
      if (!got) checkOutput($sformatf("accept_timeout_%02h", a), 0, 1);
      else      checkOutput($sformatf("accept_latency_%02h", a), cyc - c0, pa(k) + 1);
      if (c == RD) begin
         for (int n = 0; n < 40 && qSize(k) != 0; n++) @(negedge clk);
         checkOutput($sformatf("resp_pending_%02h", a), qSize(k), 0);
      end else begin
         @(negedge clk);
      end
      checkOutput($sformatf("accept_count_%02h", a), getAcc(k) - a0, 1);
   endtask

   task automatic pulseEvents(input int k, input int n);
      @(negedge clk);
      if (k == 0) evt0 = 1'b1;
      else        evt1 = 1'b1;
      repeat (n) @(negedge clk);
      evt0 = 1'b0;
      evt1 = 1'b0;
   endtask

   // Write/read scratch and control, then count 300 events and read them back atomically.
   task automatic runBasicScenarios(input int k);
      applyStimulus(k, WR, 8'h81, 8'hC3, 2'b00, 8'h00);
      applyStimulus(k, RD, 8'h81, 8'h00, 2'b01, 8'hC3);
      applyStimulus(k, WR, 8'h82, 8'h3C, 2'b00, 8'h00);
      checkOutput($sformatf("dbg_ctrl_dut%0d", k), (k == 0) ? int'(ctrl0) : int'(ctrl1), 8'h3C);
      pulseEvents(k, 300);
      applyStimulus(k, RD, 8'h83, 8'h00, 2'b01, 8'h2C);
      pulseEvents(k, 50);
      applyStimulus(k, RD, 8'h84, 8'h00, 2'b01, 8'h01);
   endtask

   initial begin
      #(20 * 20000);
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   a0;
      int   pulses;
      logic got;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      setBus(0, 3'b000, 8'h00, 8'h00);
      setBus(1, 3'b000, 8'h00, 8'h00);
      evt0 = 1'b0; evt1 = 1'b0;
      al0 = 2'b00; ls0 = 2'b00; al1 = 2'b00; ls1 = 2'b00;

      repeat (3) @(negedge clk);
      checkOutput("reset_sca", int'(sca0), 0);
      checkOutput("reset_sresp", int'(sresp0), 0);
      checkOutput("reset_sdata", int'(sdata0), 0);
      checkOutput("reset_ctrl", int'(ctrl0), 0);
      checkOutput("reset_ctrl_dut1", int'(ctrl1), 0);
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      $display("[TB] reset released");

      applyStimulus(0, RD, 8'h80, 8'h00, 2'b01, 8'h5A);
      runBasicScenarios(0);

      @(negedge clk);
      force dut0.evt_cnt = 16'hFFFE;
      @(negedge clk);
      release dut0.evt_cnt;
      pulseEvents(0, 3);
      applyStimulus(0, RD, 8'h83, 8'h00, 2'b01, 8'hFF);
      applyStimulus(0, RD, 8'h84, 8'h00, 2'b01, 8'hFF);
      evt0 = 1'b1;
      applyStimulus(0, WR, 8'h85, 8'h01, 2'b00, 8'h00);
      evt0 = 1'b0;
      applyStimulus(0, RD, 8'h83, 8'h00, 2'b01, 8'h00);
      applyStimulus(0, RD, 8'h84, 8'h00, 2'b01, 8'h00);

      applyStimulus(0, RD, 8'h87, 8'h00, 2'b11, 8'h00);
      applyStimulus(0, RD, 8'h90, 8'h00, 2'b11, 8'h00);
      applyStimulus(0, WR, 8'h80, 8'hFF, 2'b00, 8'h00);
      applyStimulus(0, RD, 8'h80, 8'h00, 2'b01, 8'h5A);
      applyStimulus(0, RD, 8'h85, 8'h00, 2'b01, 8'h00);
      al0 = 2'b10; ls0 = 2'b01;
      applyStimulus(0, RD, 8'h86, 8'h00, 2'b01, 8'h06);
      a0 = acc0;
      @(negedge clk);
      mcmd0 = 3'b011; maddr0 = 8'h81; mdata0 = 8'hAA;
      repeat (10) @(negedge clk);
      setBus(0, 3'b000, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      checkOutput("ignored_mcmd_accepts", acc0 - a0, 0);

      applyStimulus(1, WR, 8'h81, 8'h77, 2'b00, 8'h00);
      @(negedge clk);
      setBus(1, RD, 8'h81, 8'h00);
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (sca1) got = 1'b1;
      end
      setBus(1, 3'b000, 8'h00, 8'h00);
      checkOutput("abort_read_accepted", int'(got), 1);
      @(negedge clk);
      rst_n1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n1 = 1'b1;
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (sresp1 != 2'b00) pulses++;
      end
      checkOutput("abort_no_resp", pulses, 0);
      applyStimulus(1, RD, 8'h81, 8'h00, 2'b01, 8'h00);
      runBasicScenarios(1);

      repeat (5) @(negedge clk);
      checkOutput("queue_drain", q0.size() + q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
